// File: rtl/k_lut_cfg_array.sv
// k_lut_cfg_array
//   Array of N_LUT independent K-input look-up tables. Each LUT is followed by
//   an optional output flip-flop, so a LUT plus its register forms one minimal
//   logic element. Truth tables and mode bits are loaded serially through a
//   clocked configuration chain that a small IDLE/LOAD/RUN state machine
//   controls.
//
//   Per-LUT configuration slice (SLICE = 2^K+1 bits, LUT j at cfg[j*SLICE +: SLICE]):
//     bit SLICE-1   : mode, 0 = combinational output, 1 = registered output
//     bits 2^K-1..0 : truth table, entry a = result for address a
//   The first bit shifted in ends up at the cfg MSB. The stream therefore starts
//   with the mode bit of LUT N_LUT-1, then its truth bits from high to low, then
//   LUT N_LUT-2, and so on.
//
//   Optional feature, macro KLUT_READBACK_EN:
//     defined   : o_cfg_out = cfg MSB in every state (daisy-chain out while
//                 loading). In RUN, i_rb_en rotates cfg left by one bit per cycle
//                 and forces o_data to 0. After CFG_BITS rotations the original
//                 contents are back. i_cfg_start takes priority over i_rb_en.
//     undefined : o_cfg_out is tied 0, i_rb_en is ignored, and no rotate path
//                 exists.
//
// Ports
//   i_clk        clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_cfg_start  one-cycle pulse that begins (or restarts) configuration
//   i_cfg_valid  i_cfg_bit is valid this cycle
//   i_cfg_bit    serial configuration bit
//   o_cfg_ready  high in LOAD
//   o_cfg_done   high in RUN
//   i_lut_in     LUT j address = i_lut_in[j*K +: K]
//   o_data       LUT j result = o_data[j]
//   i_rb_en      readback rotate enable
//   o_cfg_out    serial configuration out / readback
//   o_dbg_state  current FSM state (0 = IDLE, 1 = LOAD, 2 = RUN)
//
// Config handshake: a bit is transferred on a rising edge where i_cfg_valid
// and o_cfg_ready are both high. The sender may hold valid low for any number
// of cycles, and no timeout applies. Valid bits offered while o_cfg_ready is
// low are dropped.

module k_lut_cfg_array #(
  parameter int K     = 4,
  parameter int N_LUT = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cfg_start,
  input  logic               i_cfg_valid,
  input  logic               i_cfg_bit,
  output logic               o_cfg_ready,
  output logic               o_cfg_done,
  input  logic [N_LUT*K-1:0] i_lut_in,
  output logic [N_LUT-1:0]   o_data,
  input  logic               i_rb_en,
  output logic               o_cfg_out,
  output logic [1:0]         o_dbg_state
);

  localparam int TT       = 1 << K;
  localparam int SLICE    = TT + 1;
  localparam int CFG_BITS = N_LUT * SLICE;
  localparam int CW       = $clog2(CFG_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t              state;
  logic [CFG_BITS-1:0] cfg;
  logic [CW-1:0]       cnt;
  logic [N_LUT-1:0]    lut_ff;
  logic [N_LUT-1:0]    lookup;
  logic [N_LUT-1:0]    mode;
  logic [TT-1:0]       tt;
  logic                rotate;

`ifdef KLUT_READBACK_EN
  // Restart wins over readback, so a start pulse never rotates the chain.
  assign rotate    = (state == RUN) && i_rb_en && !i_cfg_start;
  assign o_cfg_out = cfg[CFG_BITS-1];
`else
  logic unused_rb_en;
  assign unused_rb_en = i_rb_en;
  assign rotate       = 1'b0;
  assign o_cfg_out    = 1'b0;
`endif

  assign o_cfg_ready = (state == LOAD);
  assign o_cfg_done  = (state == RUN);
  assign o_dbg_state = state;

  // Per-LUT lookup: slice out the truth table, then index it with the address.
  always_comb begin
    lookup = '0;
    mode   = '0;
    tt     = '0;
    for (int j = 0; j < N_LUT; j++) begin
      tt        = cfg[j*SLICE +: TT];
      lookup[j] = tt[i_lut_in[j*K +: K]];
      mode[j]   = cfg[j*SLICE + TT];
    end
  end

  // Outputs are live only in RUN and not while the chain rotates, because a
  // rotated table would produce meaningless results.
  always_comb begin
    o_data = '0;
    if (state == RUN && !rotate) begin
      for (int j = 0; j < N_LUT; j++) begin
        o_data[j] = mode[j] ? lut_ff[j] : lookup[j];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      cfg    <= '0;
      cnt    <= '0;
      lut_ff <= '0;
    end else begin
      case (state)
        IDLE: begin
          lut_ff <= '0;
          if (i_cfg_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          lut_ff <= '0;
          if (i_cfg_start) begin
            // A restart that coincides with a valid bit keeps that bit as bit 1.
            if (i_cfg_valid) begin
              cfg <= {cfg[CFG_BITS-2:0], i_cfg_bit};
              cnt <= CW'(1);
            end else begin
              cnt <= '0;
            end
          end else if (i_cfg_valid) begin
            cfg <= {cfg[CFG_BITS-2:0], i_cfg_bit};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(CFG_BITS - 1)) begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (i_cfg_start) begin
            state  <= LOAD;
            cnt    <= '0;
            lut_ff <= '0;
          end
`ifdef KLUT_READBACK_EN
          else if (rotate) begin
            cfg    <= {cfg[CFG_BITS-2:0], cfg[CFG_BITS-1]};
            // Drop stale register contents so readback leaves no artefact.
            lut_ff <= '0;
          end
`endif
          else begin
            lut_ff <= lookup;
          end
        end
        default: begin
          state  <= IDLE;
          lut_ff <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k_lut_cfg_array.sv
// Self-checking bench for k_lut_cfg_array with K=4 and N_LUT=2 (34 config bits).
// Inputs are driven 1 ns after the rising edge and outputs are sampled on the
// falling edge. Expected LUT outputs come from a small model (truth tables plus
// a register image). They are pushed to exp_q when a cycle is driven and popped
// when the DUT output is sampled.

module tb_k_lut_cfg_array;
  localparam int K        = 4;
  localparam int N_LUT    = 2;
  localparam int CFG_BITS = 34;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_start;
  logic                cfg_valid;
  logic                cfg_bit;
  logic                rb_en;
  logic [N_LUT*K-1:0]  lut_in;
  logic                cfg_ready;
  logic                cfg_done;
  logic [N_LUT-1:0]    data;
  logic                cfg_out;
  logic [1:0]          dbg_state;

  always #5 clk = ~clk;

  k_lut_cfg_array #(.K(K), .N_LUT(N_LUT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cfg_start (cfg_start),
    .i_cfg_valid (cfg_valid),
    .i_cfg_bit   (cfg_bit),
    .o_cfg_ready (cfg_ready),
    .o_cfg_done  (cfg_done),
    .i_lut_in    (lut_in),
    .o_data      (data),
    .i_rb_en     (rb_en),
    .o_cfg_out   (cfg_out),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ready_cycles = 0;
  int ready_base;

  logic [N_LUT-1:0]    exp_q[$];
  logic [15:0]         m_tt[N_LUT];
  logic                m_mode[N_LUT];
  logic [N_LUT-1:0]    m_ff;
  logic [CFG_BITS-1:0] img;

  always @(negedge clk) if (cfg_ready) ready_cycles++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One config-side cycle.
  task automatic drive(input logic s, input logic v, input logic b);
    @(posedge clk); #1;
    cfg_start = s;
    cfg_valid = v;
    cfg_bit   = b;
    @(negedge clk);
  endtask

  // One RUN-side cycle with a scoreboard check of o_data.
  task automatic run_cycle(input logic [7:0] lin, input logic rb, input logic v);
    logic [N_LUT-1:0] e;
    logic [3:0]       a;
    logic             rb_on;
    @(posedge clk); #1;
    lut_in    = lin;
    rb_en     = rb;
    cfg_start = 1'b0;
    cfg_valid = v;
    cfg_bit   = 1'($urandom_range(0, 1));
`ifdef KLUT_READBACK_EN
    rb_on = rb;
`else
    rb_on = 1'b0;
`endif
    e = '0;
    for (int j = 0; j < N_LUT; j++) begin
      a = lin[j*K +: K];
      if (rb_on) begin
        e[j]    = 1'b0;
        m_ff[j] = 1'b0;
      end else begin
        e[j]    = m_mode[j] ? m_ff[j] : m_tt[j][a];
        m_ff[j] = m_tt[j][a];
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
    check_eq("o_data", 64'(data), 64'(exp_q.pop_front()));
  endtask

  task automatic load_luts(input logic md1, input logic [15:0] t1,
                           input logic md0, input logic [15:0] t0);
    img = {md1, t1, md0, t0};
    drive(1'b1, 1'b0, 1'b0);
    ready_base = ready_cycles;
    for (int i = CFG_BITS - 1; i >= 0; i--) drive(1'b0, 1'b1, img[i]);
    check_eq("done_low_at_last_bit", 64'(cfg_done), 64'd0);
    m_mode[1] = md1; m_tt[1] = t1;
    m_mode[0] = md0; m_tt[0] = t0;
    m_ff = '0;
  endtask

  // AND4 on LUT1 (combinational), XOR4 on LUT0 (registered).
  task automatic lut_sequence();
    run_cycle(8'hF1, 1'b0, 1'b0);
    check_eq("lut1_and_same_cycle", 64'(data[1]), 64'd1);
    run_cycle(8'hF1, 1'b0, 1'b0);
    check_eq("lut0_xor_next_cycle", 64'(data[0]), 64'd1);
    run_cycle(8'hE3, 1'b0, 1'b0);
    check_eq("lut1_and_drop", 64'(data[1]), 64'd0);
    run_cycle(8'hE3, 1'b0, 1'b0);
    check_eq("lut0_xor_drop", 64'(data[0]), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    rb_en = 1'b0; lut_in = '0;
    m_ff = '0;
    for (int j = 0; j < N_LUT; j++) begin m_tt[j] = '0; m_mode[j] = 1'b0; end

    // Reset and idle behaviour.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lut_in = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("idle_data", 64'(data), 64'd0);
      check_eq("idle_ready", 64'(cfg_ready), 64'd0);
      check_eq("idle_done", 64'(cfg_done), 64'd0);
      @(posedge clk); #1;
    end
    check_eq("idle_state", 64'(dbg_state), 64'd0);
    check_eq("idle_cfg_out", 64'(cfg_out), 64'd0);

    // Basic load followed by lookups.
    load_luts(1'b0, 16'h8000, 1'b1, 16'h6996);
    run_cycle(8'h00, 1'b0, 1'b0);
    check_eq("done_after_load", 64'(cfg_done), 64'd1);
    check_eq("ready_after_load", 64'(cfg_ready), 64'd0);
    check_eq("ready_cycles", 64'(ready_cycles - ready_base), 64'd34);
    lut_sequence();
    for (int i = 0; i < 20; i++) run_cycle(8'($urandom_range(0, 255)), 1'b0, 1'b0);

    // Restart during a stalled load, then load all-ones truth tables.
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'(i % 2), 1'($urandom_range(0, 1)));
    check_eq("partial_ready", 64'(cfg_ready), 64'd1);
    img = {1'b0, 16'hFFFF, 1'b1, 16'hFFFF};
    drive(1'b1, 1'b1, img[CFG_BITS-1]);
    for (int i = CFG_BITS - 2; i >= 0; i--) begin
      if (i % 2 == 0) begin
        drive(1'b0, 1'b0, 1'b0);
        check_eq("stall_ready", 64'(cfg_ready), 64'd1);
      end
      drive(1'b0, 1'b1, img[i]);
      if (i == 1) check_eq("not_done_at_33", 64'({cfg_ready, cfg_done}), 64'b10);
    end
    m_mode[1] = 1'b0; m_tt[1] = 16'hFFFF;
    m_mode[0] = 1'b1; m_tt[0] = 16'hFFFF;
    m_ff = '0;
    // Extra valid bits in RUN must be ignored.
    run_cycle(8'($urandom_range(0, 255)), 1'b0, 1'b1);
    check_eq("ones_lut1_immediate", 64'(data), 64'b10);
    run_cycle(8'($urandom_range(0, 255)), 1'b0, 1'b1);
    check_eq("ones_lut0_next", 64'(data), 64'b11);
    for (int i = 0; i < 8; i++) run_cycle(8'($urandom_range(0, 255)), 1'b0, 1'b1);
    check_eq("done_kept", 64'(cfg_done), 64'd1);

    // Reset in the middle of a load.
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_state", 64'(dbg_state), 64'd0);
    check_eq("rst_ready", 64'(cfg_ready), 64'd0);
    check_eq("rst_data", 64'(data), 64'd0);
    check_eq("rst_done", 64'(cfg_done), 64'd0);
    load_luts(1'b0, 16'h8000, 1'b1, 16'h6996);
    run_cycle(8'h00, 1'b0, 1'b0);
    check_eq("reload_done", 64'(cfg_done), 64'd1);
    check_eq("reload_ready_cycles", 64'(ready_cycles - ready_base), 64'd34);
    lut_sequence();

    // Readback rotation, or confirmation that i_rb_en is ignored.
`ifdef KLUT_READBACK_EN
    for (int i = 0; i < CFG_BITS; i++) begin
      run_cycle(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      check_eq("readback_bit", 64'(cfg_out), 64'(img[CFG_BITS-1-i]));
    end
`else
    for (int i = 0; i < 6; i++) begin
      run_cycle(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      check_eq("cfg_out_tied", 64'(cfg_out), 64'd0);
    end
`endif
    rb_en = 1'b0;
    lut_sequence();
    for (int i = 0; i < 10; i++) run_cycle(8'($urandom_range(0, 255)), 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/k_lut_cfg_array.md
Name: k_lut_cfg_array

Overview:
- Array of N_LUT independent K-input look-up tables whose truth tables are loaded over a serial configuration chain.
- Each LUT has a config-selectable output flip-flop, making it a minimal logic element: LUT plus optional register.
- Sits between the configuration loader and user logic as the next-generation, parametrised configurable logic cell.
- Config is clocked and state-machine controlled; there is no random address/data write.

Parameters:
- K, 4, inputs per LUT; truth table has 2^K bits.
- N_LUT, 2, number of LUTs in the array.
- Derived, not overridable: SLICE = 2^K+1 bits per LUT; CFG_BITS = N_LUT*SLICE.

Ports:
- i_clk  input  1  clock, all logic on rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_cfg_start  input  1  one-cycle pulse; begin (re)configuration.
- i_cfg_valid  input  1  i_cfg_bit valid this cycle.
- i_cfg_bit  input  1  serial configuration bit.
- o_cfg_ready  output  1  high in LOAD: a valid bit will be accepted.
- o_cfg_done  output  1  high in RUN.
- i_lut_in  input  N_LUT*K  LUT j address = i_lut_in[j*K +: K].
- o_data  output  N_LUT  LUT j result = o_data[j].
- i_rb_en  input  1  readback rotate enable (see Optional Feature).
- o_cfg_out  output  1  serial config out / readback (see Optional Feature).

Behaviour:
- Reset, synchronous, active-high:
  - state=IDLE, cfg register=0, bit counter=0, output FFs=0.
  - o_data=0, o_cfg_ready=0, o_cfg_done=0, o_cfg_out=0.
  - Reset asserted mid-LOAD discards the partial load and returns to IDLE.
- Config layout:
  - LUT j owns cfg[j*SLICE +: SLICE].
  - Bit SLICE-1 is the mode bit: 0 = combinational, 1 = registered.
  - Bits [2^K-1:0] are the truth table; entry a = result for address a.
- Shift: on each accepted bit, cfg <= {cfg[CFG_BITS-2:0], i_cfg_bit}. The first bit sent lands at cfg MSB, so the stream order is LUT N_LUT-1 mode bit, then its truth bits high to low, then LUT N_LUT-2, and so on.
- IDLE:
  - o_data=0.
  - i_cfg_start -> LOAD, counter=0.
- LOAD:
  - o_cfg_ready=1, o_data=0, output FFs held at 0.
  - Each cycle with i_cfg_valid=1: shift, counter+1.
  - When the accepted bit is number CFG_BITS (counter reaches CFG_BITS-1 and valid): next state RUN. o_cfg_done=1 from the following cycle; o_cfg_ready drops in the same cycle.
  - i_cfg_valid=0 stalls with no shift; there is no timeout.
  - i_cfg_start during LOAD restarts the counter at 0. If valid is also high that cycle, the bit is accepted and counts as bit 1 (counter=1).
  - Extra valid bits after completion are ignored.
- RUN:
  - Mode 0 LUT: o_data[j] = truth[i_lut_in slice], combinational, 0-cycle latency.
  - Mode 1 LUT: the FF captures the lookup each cycle; o_data[j] = FF, 1-cycle latency.
  - i_cfg_start -> LOAD. o_cfg_done clears next cycle, o_data forced 0, output FFs cleared.
- Address decode is purely by index; no out-of-range case exists.

Optional Feature:
- Macro: KLUT_READBACK_EN.
- Defined:
  - o_cfg_out = cfg[CFG_BITS-1] in all states. In LOAD this is the daisy-chain out: the previous contents stream out 1 bit per accepted bit.
  - In RUN with i_rb_en=1: cfg rotates left by 1 per cycle (cfg <= {cfg[CFG_BITS-2:0], cfg[CFG_BITS-1]}) and o_data is forced 0.
  - After exactly CFG_BITS rotate cycles the contents are restored.
  - i_cfg_start has priority over i_rb_en.
- Undefined:
  - o_cfg_out tied 0 and i_rb_en ignored.
  - The cfg register has no rotate path.

Test Plan (K=4, N_LUT=2, CFG_BITS=34):
1. Reset, then drive i_lut_in=8'hFF for 5 cycles -> o_data=0, o_cfg_ready=0, o_cfg_done=0 throughout.
2. Load LUT1: mode 0, truth 16'h8000 (AND4). Load LUT0: mode 1, truth 16'h6996 (XOR4). Send 34 contiguous valid bits.
   - o_cfg_ready high for exactly 34 cycles.
   - o_cfg_done=1 the cycle after bit 34.
3. In RUN, drive i_lut_in={4'hF,4'h1}:
   - o_data[1]=1 in the same cycle.
   - o_data[0]=1 one cycle later.
   - Then drive {4'hE,4'h3}: o_data[1]=0 immediately, o_data[0]=0 next cycle.
4. Restart the load with valid toggling every other cycle, pulse i_cfg_start again after 10 bits, then send 34 bits of all-ones.
   - Completes only after 34 bits following the restart.
   - All LUTs output 1: LUT1 combinational immediately, LUT0 one cycle later.
5. Assert i_rst after 20 bits of a load -> next cycle state IDLE, o_cfg_ready=0, o_data=0. A subsequent full load behaves as in scenario 2.
6. With KLUT_READBACK_EN, after scenario 2:
   - Assert i_rb_en for 34 cycles: o_cfg_out sequence equals the 34 loaded bits in send order, and o_data=0 throughout.
   - Deassert i_rb_en: scenario 3 results repeat exactly.
